c1_bus_responder: RTL and testbench

Cache-side responder for the CPU↔cache bus (A1/D1/C1). It decodes the CPU's three-cycle command sequence: tag/set phase, offset phase, then bus release. It forwards each command as one flat request to a cache core over a valid/ready port. When the core answers, it drives the C1 response beat(s) back to the CPU, with two beats for READ32. It sits between the CPU bus pins and the cache storage/controller, so the core never touches the tri-state bus.

---
 rtl/c1_bus_responder_if.sv | 29 ++
 rtl/c1_bus_responder.sv | 94 +++++++++
 tb/tb_c1_bus_responder.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/c1_bus_responder_if.sv
// c1_bus_responder_if: CPU A1/D1/C1 pins plus the flat core request/response port.
// D1/C1 are resolved here from each side's value and output-enable.
interface c1_bus_responder_if #(
    parameter int ADDR1_BUS_SIZE    = 15,
    parameter int DATA1_BUS_SIZE    = 16,
    parameter int CTR1_BUS_SIZE     = 4,
    parameter int CACHE_OFFSET_SIZE = 5
);
    logic [ADDR1_BUS_SIZE-1:0]                   A1;
    wire  [DATA1_BUS_SIZE-1:0]                   D1;
    wire  [CTR1_BUS_SIZE-1:0]                    C1;
    logic [DATA1_BUS_SIZE-1:0]                   rsp_d1, cpu_d1;
    logic [CTR1_BUS_SIZE-1:0]                    rsp_c1, cpu_c1;
    logic                                        rsp_d1_oe, cpu_d1_oe, rsp_c1_oe, cpu_c1_oe;
    logic                                        req_valid, req_ready, resp_valid, err;
    logic [2:0]                                  req_cmd;
    logic [ADDR1_BUS_SIZE+CACHE_OFFSET_SIZE-1:0] req_addr;
    logic [31:0]                                 req_wdata, resp_rdata;
    assign D1 = rsp_d1_oe ? rsp_d1 : (cpu_d1_oe ? cpu_d1 : 'z);
    assign C1 = rsp_c1_oe ? rsp_c1 : (cpu_c1_oe ? cpu_c1 : 'z);
    modport slave (
        input  A1, D1, C1, req_ready, resp_valid, resp_rdata,
        output rsp_d1, rsp_d1_oe, rsp_c1, rsp_c1_oe, req_valid, req_cmd, req_addr, req_wdata, err
    );
    modport master (
        output A1, cpu_d1, cpu_d1_oe, cpu_c1, cpu_c1_oe, req_ready, resp_valid, resp_rdata,
        input  D1, C1, rsp_d1, rsp_d1_oe, rsp_c1, rsp_c1_oe, req_valid, req_cmd, req_addr, req_wdata, err
    );
endinterface

// File: rtl/c1_bus_responder.sv
// c1_bus_responder: decodes the CPU three-phase A1/D1/C1 command, forwards it to the cache core, drives C1 response beats.
// Optional C1_ALIGN_CHECK_EN: misaligned 16/32-bit accesses are answered with zero data and an err strobe instead of being forwarded.
module c1_bus_responder #(
    parameter int ADDR1_BUS_SIZE    = 15,
    parameter int DATA1_BUS_SIZE    = 16,
    parameter int CTR1_BUS_SIZE     = 4,
    parameter int CACHE_OFFSET_SIZE = 5
) (
    input logic clk,
    input logic reset,
    c1_bus_responder_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ADDR2, TURN, REQ, WAIT, RESP, RESP2} state_t;
    localparam logic [2:0] READ32 = 3'd3;
    localparam logic [CTR1_BUS_SIZE-1:0] C1_RESP = CTR1_BUS_SIZE'(7);
    state_t                        state_q, state_d;
    logic [2:0]                    cmd_q, cmd_d;
    logic [ADDR1_BUS_SIZE-1:0]     hi_q, hi_d;
    logic [CACHE_OFFSET_SIZE-1:0]  off_q, off_d;
    logic [DATA1_BUS_SIZE-1:0]     wlo_q, wlo_d, whi_q, whi_d;
    logic [2*DATA1_BUS_SIZE-1:0]   rdata_q, rdata_d;
    logic                          mis, in_resp;
`ifdef C1_ALIGN_CHECK_EN
    assign mis = (cmd_q[1:0] == 2'd2 && off_q[0]) || (cmd_q[1:0] == 2'd3 && off_q[1:0] != 2'd0);
`else
    assign mis = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        hi_d    = hi_q;
        off_d   = off_q;
        wlo_d   = wlo_q;
        whi_d   = whi_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (!$isunknown(bus.C1) && bus.C1[2:0] != 3'd0) begin
                cmd_d   = bus.C1[2:0];
                hi_d    = bus.A1;
                wlo_d   = bus.D1;
                state_d = ADDR2;
            end
            ADDR2: begin
                off_d   = bus.A1[CACHE_OFFSET_SIZE-1:0];
                whi_d   = bus.D1;
                state_d = TURN;
            end
            TURN: state_d = REQ;
            REQ: if (mis) begin
                rdata_d = '0;
                state_d = RESP;
            end else if (bus.req_ready) begin
                state_d = WAIT;
            end
            WAIT: if (bus.resp_valid) begin
                rdata_d = bus.resp_rdata;
                state_d = RESP;
            end
            RESP:    state_d = cmd_q == READ32 ? RESP2 : IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            hi_q    <= '0;
            off_q   <= '0;
            wlo_q   <= '0;
            whi_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            hi_q    <= hi_d;
            off_q   <= off_d;
            wlo_q   <= wlo_d;
            whi_q   <= whi_d;
            rdata_q <= rdata_d;
        end
    end
    assign in_resp       = state_q == RESP || state_q == RESP2;
    assign bus.req_valid = state_q == REQ && !mis;
    assign bus.err       = state_q == REQ && mis;
    assign bus.req_cmd   = cmd_q;
    assign bus.req_addr  = {hi_q, off_q};
    assign bus.req_wdata = {whi_q, wlo_q};
    assign bus.rsp_c1_oe = in_resp || state_q == REQ || state_q == WAIT;
    assign bus.rsp_c1    = in_resp ? C1_RESP : '0;
    assign bus.rsp_d1_oe = in_resp;
    // INVALIDATE and all writes (cmd bit 2 set) answer with a zero data beat
    assign bus.rsp_d1    = state_q == RESP2 ? rdata_q[2*DATA1_BUS_SIZE-1:DATA1_BUS_SIZE]
                         : (cmd_q[2] ? '0 : rdata_q[DATA1_BUS_SIZE-1:0]);
endmodule

// File: tb/tb_c1_bus_responder.sv
// tb_c1_bus_responder: directed transactions against a transaction-level model of the responder.
module tb_c1_bus_responder;
`ifdef C1_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    c1_bus_responder_if bif ();
    c1_bus_responder dut (.clk(clk), .reset(reset), .bus(bif));

    int checks = 0;
    int errors = 0;
    logic [2:0]  exp_cmd;
    logic [19:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [15:0] exp_b [2];
    logic [15:0] cap_b [2];
    int exp_n = 0, exp_err = 0, beats_seen = 0, err_seen = 0, valid_cycles = 0;
    logic [2:0]  cap_cmd;
    logic [19:0] cap_addr;
    logic [31:0] cap_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit misaligned(input logic [2:0] c, input logic [19:0] a);
        int sz;
        sz = (c == 3'd2 || c == 3'd6) ? 2 : ((c == 3'd3 || c == 3'd7) ? 4 : 1);
        return ALIGN && (int'(a) % sz != 0);
    endfunction

    always @(negedge clk) begin
        if (bif.req_valid) begin
            valid_cycles++;
            chk("req_cmd", 32'(bif.req_cmd), 32'(exp_cmd));
            chk("req_addr", 32'(bif.req_addr), 32'(exp_addr));
            chk("req_wdata", bif.req_wdata, exp_wdata);
        end
        if (bif.err) err_seen++;
        if (bif.rsp_c1_oe && bif.C1 == 4'd7) begin
            chk("beat_d1_oe", 32'(bif.rsp_d1_oe), 32'd1);
            if (beats_seen < exp_n) chk("beat_data", 32'(bif.D1), 32'(exp_b[beats_seen]));
            else chk("extra_beat", 32'(beats_seen), 32'(exp_n));
            if (beats_seen < 2) cap_b[beats_seen] = bif.D1;
            beats_seen++;
        end else begin
            chk("d1_off_outside_resp", 32'(bif.rsp_d1_oe), 32'd0);
            if (bif.rsp_c1_oe) chk("c1_nop", 32'(bif.C1), 32'd0);
        end
    end

    task automatic txn(input logic [2:0] cmd, input logic [19:0] addr, input logic [31:0] wd,
                       input logic [31:0] rd, input int rdy_dly, input int rsp_dly, input bit abort);
        bit mis, hs;
        int seen;
        logic [31:0] rdv;
        mis = misaligned(cmd, addr);
        rdv = mis ? 32'd0 : rd;
        exp_cmd = cmd; exp_addr = addr; exp_wdata = wd;
        exp_n = abort ? 0 : (cmd == 3'd3 ? 2 : 1);
        exp_b[0] = cmd >= 3'd4 ? 16'd0 : rdv[15:0];
        exp_b[1] = rdv[31:16];
        exp_err = mis ? 1 : 0;
        beats_seen = 0; err_seen = 0; valid_cycles = 0;
        cap_b[0] = 16'hxxxx; cap_b[1] = 16'hxxxx;
        bif.cpu_c1_oe = 1'b1; bif.cpu_c1 = {1'b0, cmd};
        bif.A1 = addr[19:5]; bif.cpu_d1_oe = 1'b1; bif.cpu_d1 = wd[15:0];
        @(posedge clk); #1;
        bif.cpu_c1_oe = 1'b0; bif.A1 = {10'd0, addr[4:0]}; bif.cpu_d1 = wd[31:16];
        @(posedge clk); #1;
        bif.cpu_d1_oe = 1'b0; bif.A1 = '0;
        hs = 1'b0;
        if (!mis) begin
            seen = 0;
            for (int n = 0; n < 60 && !hs; n++) begin
                @(negedge clk);
                if (bif.req_valid) begin
                    seen++;
                    if (seen > rdy_dly) begin
                        cap_cmd = bif.req_cmd; cap_addr = bif.req_addr; cap_wdata = bif.req_wdata;
                        bif.req_ready = 1'b1;
                        @(posedge clk); #1;
                        bif.req_ready = 1'b0;
                        hs = 1'b1;
                    end
                end
            end
            chk("handshake_seen", 32'(hs), 32'd1);
            if (hs && abort) begin
                reset = 1'b0;
                @(posedge clk); #1;
                reset = 1'b1;
                @(negedge clk);
                chk("rst_c1_oe", 32'(bif.rsp_c1_oe), 32'd0);
                chk("rst_d1_oe", 32'(bif.rsp_d1_oe), 32'd0);
                chk("rst_req_addr", 32'(bif.req_addr), 32'd0);
                chk("rst_req_wdata", bif.req_wdata, 32'd0);
                bif.resp_valid = 1'b1; bif.resp_rdata = rd;
                @(posedge clk); #1;
                bif.resp_valid = 1'b0;
            end else if (hs) begin
                repeat (rsp_dly) @(posedge clk);
                #1;
                bif.resp_valid = 1'b1; bif.resp_rdata = rd;
                @(posedge clk); #1;
                bif.resp_valid = 1'b0; bif.resp_rdata = '0;
            end
        end
        repeat (6) @(posedge clk);
        #1;
        chk("beat_count", 32'(beats_seen), 32'(exp_n));
        chk("err_count", 32'(err_seen), 32'(exp_err));
        chk("valid_cycles", 32'(valid_cycles), mis ? 32'd0 : 32'(rdy_dly + 1));
    endtask

    initial begin
        bif.A1 = '0; bif.cpu_d1 = '0; bif.cpu_c1 = '0; bif.cpu_d1_oe = 1'b0; bif.cpu_c1_oe = 1'b0;
        bif.req_ready = 1'b0; bif.resp_valid = 1'b0; bif.resp_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_req_valid", 32'(bif.req_valid), 32'd0);
        chk("reset_err", 32'(bif.err), 32'd0);
        chk("reset_c1_oe", 32'(bif.rsp_c1_oe), 32'd0);
        chk("reset_d1_oe", 32'(bif.rsp_d1_oe), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        txn(3'd7, 20'h00000, 32'h00000001, 32'hDEADBEEF, 0, 0, 1'b0);
        chk("w32_cmd", 32'(cap_cmd), 32'd7);
        chk("w32_addr", 32'(cap_addr), 32'h0);
        chk("w32_wdata", cap_wdata, 32'h00000001);
        chk("w32_beat", 32'(cap_b[0]), 32'h0);

        txn(3'd3, 20'h00200, 32'h0, 32'h00030002, 0, 0, 1'b0);
        chk("r32_addr", 32'(cap_addr), 32'h200);
        chk("r32_beat0", 32'(cap_b[0]), 32'h0002);
        chk("r32_beat1", 32'(cap_b[1]), 32'h0003);

        txn(3'd1, 20'h00401, 32'h0, 32'h000000AB, 0, 2, 1'b0);
        chk("r8_cmd", 32'(cap_cmd), 32'd1);
        chk("r8_addr", 32'(cap_addr), 32'h401);
        chk("r8_beat", 32'(cap_b[0]), 32'h00AB);

        txn(3'd4, 20'h003E0, 32'h0, 32'h55AA55AA, 5, 0, 1'b0);
        chk("inv_beat", 32'(cap_b[0]), 32'h0);

        txn(3'd6, 20'h01234, 32'hBEEF_CAFE, 32'h0, 0, 1, 1'b1);
        txn(3'd2, 20'h00002, 32'h0, 32'h12345678, 1, 0, 1'b0);
        chk("r16_beat", 32'(cap_b[0]), 32'h5678);

        txn(3'd5, 20'hFFFFF, 32'hA5A5_5A5A, 32'h9999_8888, 2, 3, 1'b0);

        txn(3'd3, 20'h00002, 32'h0, 32'h11112222, 0, 0, 1'b0);
`ifdef C1_ALIGN_CHECK_EN
        chk("mis_err", 32'(err_seen), 32'd1);
        chk("mis_beat0", 32'(cap_b[0]), 32'h0);
        chk("mis_beat1", 32'(cap_b[1]), 32'h0);
`else
        chk("noalign_err", 32'(err_seen), 32'd0);
        chk("noalign_beat0", 32'(cap_b[0]), 32'h2222);
        chk("noalign_beat1", 32'(cap_b[1]), 32'h1111);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
